// File: rtl/traffic_signal_ctrl.sv
// traffic_signal_ctrl: timed highway/crosswalk signal controller with latched side request
// Optional flashing mode is built in when the TRAFFIC_FLASH_EN macro is defined.
module traffic_signal_ctrl #(
  parameter int CNT_W        = 8,
  parameter int HW_MIN_GREEN = 8,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int CW_MIN_GREEN = 4,
  parameter int CW_MAX_GREEN = 10
`ifdef TRAFFIC_FLASH_EN
  ,
  parameter int FLASH_HALF   = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash,
`endif
  output logic [1:0] hw,
  output logic [1:0] cw,
  output logic [2:0] phase,
  output logic       req_pend
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  localparam logic [CNT_W-1:0] T_HG    = CNT_W'(HW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_AR    = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] T_CWMIN = CNT_W'(CW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_CWMAX = CNT_W'(CW_MAX_GREEN - 1);
`ifdef TRAFFIC_FLASH_EN
  localparam logic [CNT_W-1:0] T_FL    = CNT_W'(FLASH_HALF - 1);
`endif

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
`ifdef TRAFFIC_FLASH_EN
    ,
    FL  = 3'd6
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             req_q, req_d;
`ifdef TRAFFIC_FLASH_EN
  logic             blink_q, blink_d;
`endif

  // next phase: timed exits, demand-gated highway release, bounded crosswalk green
  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:  if (timer_q >= T_HG && (req_q || x)) state_d = HY;
      HY:  if (timer_q == T_YEL) state_d = AR1;
      AR1: if (timer_q == T_AR) state_d = CG;
      CG:  if (timer_q >= T_CWMIN && (!x || timer_q == T_CWMAX)) state_d = CY;
      CY:  if (timer_q == T_YEL) state_d = AR2;
      AR2: if (timer_q == T_AR) state_d = HG;
`ifdef TRAFFIC_FLASH_EN
      FL:  state_d = AR2;
`endif
      default: state_d = HG;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (flash) state_d = FL;
`endif
  end

  // phase timer: restarts on every phase change, holds at the HG and CG limits
  always_comb begin
    timer_d = timer_q + CNT_W'(1);
    if (state_d != state_q) timer_d = '0;
    else if (state_q == HG && timer_q >= T_HG) timer_d = T_HG;
    else if (state_q == CG && timer_q >= T_CWMAX) timer_d = T_CWMAX;
`ifdef TRAFFIC_FLASH_EN
    else if (state_q == FL && timer_q >= T_FL) timer_d = '0;
`endif
  end

  // crosswalk request latch: armed during highway phases, consumed on entering CG
  always_comb begin
    req_d = req_q;
    if (x && (state_q == HG || state_q == HY || state_q == AR1)) req_d = 1'b1;
    if (state_q != HG && state_q != CG && state_d == CG) req_d = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    if (state_d == FL) req_d = 1'b0;
`endif
  end

`ifdef TRAFFIC_FLASH_EN
  // flash lamp phase: starts lit (yellow) on entry, flips every FLASH_HALF cycles
  always_comb begin
    blink_d = (state_q != FL) ? 1'b1 : (timer_q >= T_FL) ? ~blink_q : blink_q;
  end
`endif

  // lamp and status decode straight from the state register
  always_comb begin
    hw = RED;
    cw = RED;
    case (state_q)
      HG: hw = GRN;
      HY: hw = YEL;
      CG: cw = GRN;
      CY: cw = YEL;
`ifdef TRAFFIC_FLASH_EN
      FL: hw = blink_q ? YEL : RED;
`endif
      default: ;
    endcase
    phase    = state_q;
    req_pend = req_q;
  end

  // state, timer and request registers with asynchronous reset to HG
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HG;
      timer_q <= '0;
      req_q   <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
`ifdef TRAFFIC_FLASH_EN
      blink_q <= blink_d;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// tb_traffic_signal_ctrl: scoreboard bench for traffic_signal_ctrl against a phase/duration model
module tb_traffic_signal_ctrl;

  localparam int HW_MIN = 8;
  localparam int YEL_T  = 3;
  localparam int AR_T   = 2;
  localparam int CWMIN  = 4;
  localparam int CWMAX  = 10;
  localparam int FH     = 4;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       flash = 1'b0;
  logic [1:0] hw, cw;
  logic [2:0] phase;
  logic       req_pend;

  traffic_signal_ctrl #(
    .CNT_W(8), .HW_MIN_GREEN(HW_MIN), .YELLOW_TIME(YEL_T), .ALL_RED_TIME(AR_T),
    .CW_MIN_GREEN(CWMIN), .CW_MAX_GREEN(CWMAX)
`ifdef TRAFFIC_FLASH_EN
    , .FLASH_HALF(FH)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .x(x),
`ifdef TRAFFIC_FLASH_EN
    .flash(flash),
`endif
    .hw(hw),
    .cw(cw),
    .phase(phase),
    .req_pend(req_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] hw;
    logic [1:0] cw;
    logic [2:0] ph;
    logic       req;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: named phase, cycles already spent in it, latched request
  int m_ph = 0;
  int m_n  = 0;
  bit m_req = 0;

  function automatic exp_t model_out();
    exp_t e;
    e.ph  = 3'(m_ph);
    e.req = m_req;
    e.hw  = RED;
    e.cw  = RED;
    if (m_ph == 0) e.hw = GRN;
    if (m_ph == 1) e.hw = YEL;
    if (m_ph == 3) e.cw = GRN;
    if (m_ph == 4) e.cw = YEL;
    if (m_ph == 6) e.hw = ((m_n / FH) % 2 == 0) ? YEL : RED;
    return e;
  endfunction

  task automatic model_advance(input bit xv, input bit fv);
    int t, nxt;
    bit nreq;
    t = m_n + 1;
    nxt = m_ph;
    nreq = m_req | (xv && m_ph <= 2);
    case (m_ph)
      0: if (t >= HW_MIN && (m_req || xv)) nxt = 1;
      1: if (t == YEL_T) nxt = 2;
      2: if (t == AR_T) nxt = 3;
      3: if (t >= CWMIN && (!xv || t == CWMAX)) nxt = 4;
      4: if (t == YEL_T) nxt = 5;
      5: if (t == AR_T) nxt = 0;
      6: if (!fv) nxt = 5;
      default: nxt = 0;
    endcase
    if (fv) nxt = 6;
    if (nxt == 3 && m_ph != 3) nreq = 0;
    if (nxt == 6) nreq = 0;
    m_n = (nxt != m_ph) ? 0 : t;
    m_ph = nxt;
    m_req = nreq;
  endtask

  // one clock of stimulus: expectation for this cycle is queued before inputs change
  task automatic step(input bit xv, input bit rv, input bit fv);
    @(negedge clk);
    reset = rv;
    if (rv) begin
      m_ph = 0;
      m_n = 0;
      m_req = 0;
    end
    q.push_back(model_out());
    x = xv;
`ifdef TRAFFIC_FLASH_EN
    flash = fv;
`endif
    if (!rv) model_advance(xv, fv);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: pops one expectation per cycle, sampled mid-low-phase
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hw", int'(hw), int'(e.hw));
      chk("cw", int'(cw), int'(e.cw));
      chk("phase", int'(phase), int'(e.ph));
      chk("req_pend", int'(req_pend), int'(e.req));
      chk("safety", int'(hw == GRN && cw != RED), 0);
    end
  end

  initial begin
    // idle highway with no demand
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0);
    // single-cycle request at cycle 1
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    // continuous demand: crosswalk green capped at max
    step(0, 1, 0);
    for (int i = 0; i < 90; i++) step(1, 0, 0);
    // pulse at cycle 20 after a cycle-1 request, then pulse inside CG
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(i == 1 || i == 20 || i == 14 || i == 9, 0, 0);
    // reset in the second CG cycle, then continuous demand
    step(0, 1, 0);
    for (int i = 0; i < 14; i++) step(i == 1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    // randomized demand with occasional bursts and rare resets
    step(0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      bit xv;
      xv = (i % 100 < 30) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 5) == 0);
      step(xv, $urandom_range(0, 149) == 0, 0);
    end
`ifdef TRAFFIC_FLASH_EN
    // flash request for 20 cycles starting at cycle 5
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(i == 2, 0, i >= 5 && i < 25);
    for (int i = 0; i < 200; i++) step($urandom_range(0, 3) == 0, 0, $urandom_range(0, 19) == 0);
`endif
    @(negedge clk);
    #5;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
